// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - consumer-side handshake bundle for the UART receive sequencer
interface uart_rx_ctrl_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       clr_ovr;

  modport master (
    output data_out, data_valid, frame_err, overrun,
    input  data_ready, clr_ovr
  );

  modport slave (
    input  data_out, data_valid, frame_err, overrun,
    output data_ready, clr_ovr
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive sequencer: oversample timer, bit sequencing, holding register
module uart_rx_ctrl #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_rxd,
  input  logic [7:0]     i_data_in,
  output logic           o_bit_tick,
  output logic [2:0]     o_bit_cnt,
  output logic           o_busy,
  uart_rx_ctrl_if.master cons
);
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t           r_state;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_cnt;
  logic             r_tick;
  logic [7:0]       r_data;
  logic             r_valid;
  logic             r_ferr;
  logic             r_ovr;

  logic             w_rxd_s;
  logic             w_pop;
  logic             w_cnt_full;

  assign w_rxd_s    = r_sync[1];
  assign w_pop      = r_valid & cons.data_ready;
  assign w_cnt_full = (r_cnt == FULL_M1);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state   <= S_IDLE;
      r_sync    <= 2'b11;
      r_cnt     <= '0;
      r_bit_cnt <= 3'd0;
      r_tick    <= 1'b0;
      r_data    <= 8'h00;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_rxd};
      r_tick <= 1'b0;
      r_ferr <= 1'b0;
      if (w_pop) r_valid <= 1'b0;
      if (cons.clr_ovr) r_ovr <= 1'b0;
      // bit_cnt advances the cycle after its tick so it is stable while the tick is high
      if (r_tick && r_state == S_DATA) r_bit_cnt <= r_bit_cnt + 3'd1;

      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rxd_s) r_state <= S_START;
        end
        S_START: begin
          if (r_cnt == HALF_M1) begin
            r_cnt <= '0;
            if (!w_rxd_s) begin
              r_state   <= S_DATA;
              r_bit_cnt <= 3'd0;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_full) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_STOP: begin
          if (w_cnt_full) begin
            r_cnt <= '0;
            if (w_rxd_s) begin
              r_state <= S_IDLE;
              // a pop in this same cycle frees the slot, so the new byte is kept
              if (!r_valid || w_pop) begin
                r_data  <= i_data_in;
                r_valid <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end else begin
              r_ferr  <= 1'b1;
              r_state <= S_BREAK;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (w_rxd_s) r_state <= S_IDLE;
        end
        default: begin
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_bit_tick      = r_tick;
  assign o_bit_cnt       = r_bit_cnt;
  assign o_busy          = (r_state != S_IDLE);
  assign cons.data_out   = r_data;
  assign cons.data_valid = r_valid;
  assign cons.frame_err  = r_ferr;
  assign cons.overrun    = r_ovr;
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed self-checking bench for uart_rx_ctrl at 16 clocks per bit
module tb_uart_rx_ctrl;
  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic [7:0] data_in;
  logic       bit_tick;
  logic [2:0] bit_cnt;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_ctrl_if u_if ();

  uart_rx_ctrl #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rxd      (rxd),
    .i_data_in  (data_in),
    .o_bit_tick (bit_tick),
    .o_bit_cnt  (bit_cnt),
    .o_busy     (busy),
    .cons       (u_if)
  );

  int total = 0;
  int bad   = 0;

  // receive datapath model: shift in the line at each mid-bit tick
  logic [7:0] dp_byte = 8'h00;
  always @(posedge clk) if (bit_tick) dp_byte[bit_cnt] <= rxd;
  assign data_in = dp_byte;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int         tick_n, ferr_n, valid_n, busy_n;
  int         tick_t [8];
  logic [2:0] tick_idx [8];
  int         busy_rise_t, busy_fall_t, valid_rise_t, frame_t0;
  logic       prev_busy = 1'b0;
  logic       prev_valid = 1'b0;

  always @(negedge clk) begin
    if (bit_tick === 1'b1) begin
      if (tick_n < 8) begin
        tick_t[tick_n]   = cyc;
        tick_idx[tick_n] = bit_cnt;
      end
      tick_n++;
    end
    if (u_if.frame_err === 1'b1) ferr_n++;
    if (u_if.data_valid === 1'b1) valid_n++;
    if (busy === 1'b1) busy_n++;
    if (busy === 1'b1 && prev_busy === 1'b0) busy_rise_t = cyc;
    if (busy === 1'b0 && prev_busy === 1'b1) busy_fall_t = cyc;
    if (u_if.data_valid === 1'b1 && prev_valid === 1'b0) valid_rise_t = cyc;
    prev_busy  = busy;
    prev_valid = u_if.data_valid;
  end

  task automatic clear_mon();
    tick_n       = 0;
    ferr_n       = 0;
    valid_n      = 0;
    busy_n       = 0;
    busy_rise_t  = -1;
    busy_fall_t  = -1;
    valid_rise_t = -1;
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // drives the first ncyc cycles of a frame; optionally pulses data_ready on the stop-sample cycle
  task automatic send_frame(input logic [7:0] b, input logic stop, input int ncyc, input bit pulse_rdy);
    frame_t0 = cyc;
    for (int c = 0; c < ncyc; c++) begin
      if (c < 16) rxd = 1'b0;
      else if (c < 144) rxd = b[(c - 16) / 16];
      else rxd = stop;
      if (pulse_rdy && c == 154) u_if.data_ready = 1'b1;
      else if (pulse_rdy && c == 155) u_if.data_ready = 1'b0;
      step(1);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rxd = 1'b1;
    u_if.data_ready = 1'b0;
    u_if.clr_ovr = 1'b0;
    step(2);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    total++; if (bit_tick !== 1'b0) begin bad++; $display("FAIL reset_tick got=%0b want=0", bit_tick); end
    total++; if (bit_cnt !== 3'd0) begin bad++; $display("FAIL reset_bit_cnt got=%0d want=0", bit_cnt); end
    total++; if (u_if.data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out got=%h want=00", u_if.data_out); end
    total++; if (u_if.data_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", u_if.data_valid); end
    total++; if (u_if.frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%0b want=0", u_if.frame_err); end
    total++; if (u_if.overrun !== 1'b0) begin bad++; $display("FAIL reset_ovr got=%0b want=0", u_if.overrun); end
    rst_n = 1'b1;
    step(4);
  endtask

  task automatic test_good_frame();
    u_if.data_ready = 1'b1;
    clear_mon();
    send_frame(8'hA5, 1'b1, 160, 1'b0);
    step(4);
    total++; if (tick_n !== 8) begin bad++; $display("FAIL good_tick_count got=%0d want=8", tick_n); end
    for (int i = 0; i < 8; i++) begin
      total++; if (tick_idx[i] !== 3'(i)) begin bad++; $display("FAIL good_bit_cnt[%0d] got=%0d want=%0d", i, tick_idx[i], i); end
    end
    for (int i = 1; i < 8; i++) begin
      total++; if (tick_t[i] - tick_t[i-1] !== 16) begin bad++; $display("FAIL good_tick_gap[%0d] got=%0d want=16", i, tick_t[i] - tick_t[i-1]); end
    end
    total++; if (busy_rise_t - frame_t0 !== 3) begin bad++; $display("FAIL good_busy_latency got=%0d want=3", busy_rise_t - frame_t0); end
    total++; if (tick_t[0] - busy_rise_t !== 24) begin bad++; $display("FAIL good_first_tick got=%0d want=24", tick_t[0] - busy_rise_t); end
    total++; if (valid_rise_t - tick_t[7] !== 16) begin bad++; $display("FAIL good_valid_latency got=%0d want=16", valid_rise_t - tick_t[7]); end
    total++; if (busy_fall_t !== valid_rise_t) begin bad++; $display("FAIL good_busy_fall got=%0d want=%0d", busy_fall_t, valid_rise_t); end
    total++; if (u_if.data_out !== 8'hA5) begin bad++; $display("FAIL good_data got=%h want=a5", u_if.data_out); end
    total++; if (valid_n !== 1) begin bad++; $display("FAIL good_valid_cycles got=%0d want=1", valid_n); end
    total++; if (ferr_n !== 0) begin bad++; $display("FAIL good_ferr got=%0d want=0", ferr_n); end
    total++; if (u_if.overrun !== 1'b0) begin bad++; $display("FAIL good_ovr got=%0b want=0", u_if.overrun); end
  endtask

  task automatic test_glitch();
    clear_mon();
    rxd = 1'b0;
    step(4);
    rxd = 1'b1;
    step(20);
    total++; if (busy_n !== 8) begin bad++; $display("FAIL glitch_busy_cycles got=%0d want=8", busy_n); end
    total++; if (tick_n !== 0) begin bad++; $display("FAIL glitch_ticks got=%0d want=0", tick_n); end
    total++; if (valid_n !== 0) begin bad++; $display("FAIL glitch_valid got=%0d want=0", valid_n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%0b want=0", busy); end
  endtask

  task automatic test_frame_err();
    u_if.data_ready = 1'b0;
    clear_mon();
    send_frame(8'h3C, 1'b0, 160, 1'b0);
    step(40);
    total++; if (tick_n !== 8) begin bad++; $display("FAIL ferr_ticks got=%0d want=8", tick_n); end
    total++; if (ferr_n !== 1) begin bad++; $display("FAIL ferr_pulse_cycles got=%0d want=1", ferr_n); end
    total++; if (valid_n !== 0) begin bad++; $display("FAIL ferr_valid got=%0d want=0", valid_n); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_held got=%0b want=1", busy); end
    rxd = 1'b1;
    step(2);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_sync got=%0b want=1", busy); end
    step(1);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release got=%0b want=0", busy); end
    step(4);
  endtask

  task automatic test_overrun();
    u_if.data_ready = 1'b0;
    clear_mon();
    send_frame(8'h11, 1'b1, 160, 1'b0);
    send_frame(8'h22, 1'b1, 160, 1'b0);
    step(4);
    total++; if (u_if.data_out !== 8'h11) begin bad++; $display("FAIL ovr_data got=%h want=11", u_if.data_out); end
    total++; if (u_if.data_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%0b want=1", u_if.data_valid); end
    total++; if (u_if.overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%0b want=1", u_if.overrun); end
    u_if.clr_ovr = 1'b1;
    step(1);
    u_if.clr_ovr = 1'b0;
    total++; if (u_if.overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%0b want=0", u_if.overrun); end
    total++; if (u_if.data_out !== 8'h11) begin bad++; $display("FAIL ovr_data_hold got=%h want=11", u_if.data_out); end
    u_if.data_ready = 1'b1;
    step(1);
    u_if.data_ready = 1'b0;
    total++; if (u_if.data_valid !== 1'b0) begin bad++; $display("FAIL ovr_pop got=%0b want=0", u_if.data_valid); end
    step(4);
  endtask

  task automatic test_back_to_back();
    u_if.data_ready = 1'b0;
    send_frame(8'h11, 1'b1, 160, 1'b0);
    total++; if (u_if.data_out !== 8'h11) begin bad++; $display("FAIL b2b_first got=%h want=11", u_if.data_out); end
    send_frame(8'h22, 1'b1, 160, 1'b1);
    step(2);
    total++; if (u_if.data_out !== 8'h22) begin bad++; $display("FAIL b2b_data got=%h want=22", u_if.data_out); end
    total++; if (u_if.data_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%0b want=1", u_if.data_valid); end
    total++; if (u_if.overrun !== 1'b0) begin bad++; $display("FAIL b2b_ovr got=%0b want=0", u_if.overrun); end
  endtask

  task automatic test_reset_midframe();
    clear_mon();
    send_frame(8'h99, 1'b1, 77, 1'b0);
    total++; if (tick_n !== 4) begin bad++; $display("FAIL mid_ticks got=%0d want=4", tick_n); end
    total++; if (tick_idx[3] !== 3'd3) begin bad++; $display("FAIL mid_last_idx got=%0d want=3", tick_idx[3]); end
    rxd = 1'b1;
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0b want=0", busy); end
    total++; if (bit_tick !== 1'b0) begin bad++; $display("FAIL mid_tick got=%0b want=0", bit_tick); end
    total++; if (u_if.data_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%0b want=0", u_if.data_valid); end
    total++; if (bit_cnt !== 3'd0) begin bad++; $display("FAIL mid_bit_cnt got=%0d want=0", bit_cnt); end
    step(4);
    u_if.data_ready = 1'b1;
    clear_mon();
    send_frame(8'h5A, 1'b1, 160, 1'b0);
    step(4);
    total++; if (u_if.data_out !== 8'h5A) begin bad++; $display("FAIL post_data got=%h want=5a", u_if.data_out); end
    total++; if (valid_n !== 1) begin bad++; $display("FAIL post_valid_cycles got=%0d want=1", valid_n); end
    total++; if (ferr_n !== 0) begin bad++; $display("FAIL post_ferr got=%0d want=0", ferr_n); end
    total++; if (tick_n !== 8) begin bad++; $display("FAIL post_ticks got=%0d want=8", tick_n); end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_good_frame();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
